// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared UART/FIFO widths and the per-cycle request encoding
package uart_fifo_pkg;

  localparam int DBIT   = 8;  // UART data bits
  localparam int FIFO_W = 4;  // default FIFO address width

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - FIFO pointers, occupancy, empty/full and sticky error flags
import uart_fifo_pkg::*;

module fifo_ctrl #(
  parameter int W = FIFO_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_wr,
  input  logic         i_rd,
  input  logic         i_clr_flags,
  output logic         o_we,
  output logic [W-1:0] o_w_ptr,
  output logic [W-1:0] o_r_ptr,
  output logic         o_empty,
  output logic         o_full,
  output logic [W:0]   o_count,
  output logic         o_overflow,
  output logic         o_underflow
);

  localparam logic [W:0] DEPTH = (W+1)'(1) << W;

  logic [W-1:0] r_w_ptr, r_r_ptr;
  logic [W:0]   r_count;
  logic         r_empty, r_full, r_overflow, r_underflow;

  fifo_op_e     w_op;
  logic         w_push, w_pop, w_ovf_evt, w_udf_evt;
  logic [W:0]   w_count_nxt;

  // Decode uses only registered empty/full, so wr/rd never reach status combinationally
  always_comb begin
    w_op      = fifo_op_e'({i_wr, i_rd});
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_evt = 1'b0;
    w_udf_evt = 1'b0;
    unique case (w_op)
      OP_POP:  if (r_empty) w_udf_evt = 1'b1; else w_pop  = 1'b1;
      OP_PUSH: if (r_full)  w_ovf_evt = 1'b1; else w_push = 1'b1;
      OP_BOTH: begin
        w_push = 1'b1;
        w_pop  = !r_empty;
      end
      default: ;
    endcase
    w_count_nxt = r_count + (W+1)'(w_push) - (W+1)'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_w_ptr     <= '0;
      r_r_ptr     <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_w_ptr <= r_w_ptr + W'(1);
      if (w_pop)  r_r_ptr <= r_r_ptr + W'(1);
      r_count     <= w_count_nxt;
      r_empty     <= (w_count_nxt == '0);
      r_full      <= (w_count_nxt == DEPTH);
      r_overflow  <= (r_overflow  && !i_clr_flags) || w_ovf_evt;
      r_underflow <= (r_underflow && !i_clr_flags) || w_udf_evt;
    end
  end

  assign o_we        = w_push;
  assign o_w_ptr     = r_w_ptr;
  assign o_r_ptr     = r_r_ptr;
  assign o_empty     = r_empty;
  assign o_full      = r_full;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word-fall-through FIFO for received UART bytes
import uart_fifo_pkg::*;

module uart_fifo #(
  parameter int B = DBIT,
  parameter int W = FIFO_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic [W:0]   count,
  input  logic         clr_flags,
  output logic         overflow,
  output logic         underflow
);

  logic [B-1:0] r_mem [2**W];
  logic         w_we;
  logic [W-1:0] w_w_ptr, w_r_ptr;

  fifo_ctrl #(.W(W)) u_ctrl (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_wr        (wr),
    .i_rd        (rd),
    .i_clr_flags (clr_flags),
    .o_we        (w_we),
    .o_w_ptr     (w_w_ptr),
    .o_r_ptr     (w_r_ptr),
    .o_empty     (empty),
    .o_full      (full),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_underflow (underflow)
  );

  // Storage is deliberately not reset; contents are meaningless while empty
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_w_ptr] <= w_data;
  end

  assign r_data = r_mem[w_r_ptr];

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - randomized bench for uart_fifo against a queue reference model
module tb_uart_fifo;

  logic       clk = 1'b0;
  logic       reset_n, wr, rd, clr_flags;
  logic [7:0] w_data, r_data;
  logic       empty, full, overflow, underflow;
  logic [4:0] count;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] m_q[$];
  logic       m_ovf, m_udf;

  uart_fifo dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (wr),
    .w_data    (w_data),
    .rd        (rd),
    .r_data    (r_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .clr_flags (clr_flags),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"},     32'(count),     32'(m_q.size()));
    chk({tag, ".empty"},     32'(empty),     32'(m_q.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(m_q.size() == 16));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    if (m_q.size() > 0) chk({tag, ".r_data"}, 32'(r_data), 32'(m_q[0]));
  endtask

  // Model follows the behavioural rules directly: a byte queue plus two flags
  task automatic model_step(input logic w, input logic r, input logic [7:0] d,
                            input logic c, input logic rn);
    logic ovf_evt, udf_evt;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (!rn) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    if (w && r) begin
      if (m_q.size() != 0) void'(m_q.pop_front());
      m_q.push_back(d);
    end else if (w) begin
      if (m_q.size() < 16) m_q.push_back(d);
      else ovf_evt = 1'b1;
    end else if (r) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else udf_evt = 1'b1;
    end
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    m_ovf = m_ovf | ovf_evt;
    m_udf = m_udf | udf_evt;
  endtask

  task automatic cyc(input string tag, input logic w, input logic r, input logic [7:0] d,
                     input logic c, input logic rn);
    wr = w; rd = r; w_data = d; clr_flags = c; reset_n = rn;
    @(posedge clk);
    model_step(w, r, d, c, rn);
    #1;
    check_state(tag);
  endtask

  initial begin
    int phase_bias;
    wr = 1'b0; rd = 1'b0; w_data = '0; clr_flags = 1'b0; reset_n = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0;

    // reset dominates a concurrent write
    cyc("reset", 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    chk("reset.count_const", 32'(count), 32'd0);

    // ordering
    cyc("order_push", 1'b1, 1'b0, 8'h41, 1'b0, 1'b1);
    cyc("order_push", 1'b1, 1'b0, 8'h42, 1'b0, 1'b1);
    cyc("order_push", 1'b1, 1'b0, 8'h43, 1'b0, 1'b1);
    chk("order.head_const", 32'(r_data), 32'h41);
    for (int i = 0; i < 3; i++) cyc("order_pop", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("order.empty_const", 32'(empty), 32'd1);

    // fill, overflow, drain across pointer wrap
    for (int i = 0; i < 16; i++) cyc("fill_push", 1'b1, 1'b0, 8'(i), 1'b0, 1'b1);
    chk("fill.full_const", 32'(full), 32'd1);
    chk("fill.count_const", 32'(count), 32'd16);
    cyc("fill_drop", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
    chk("fill.ovf_const", 32'(overflow), 32'd1);
    for (int i = 0; i < 10; i++) cyc("wrap_pop", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    cyc("wrap_push", 1'b1, 1'b0, 8'h10, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc("wrap_pop", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("wrap.head_const", 32'(r_data), 32'h10);
    cyc("wrap_pop", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);

    // simultaneous push/pop on empty and on full
    cyc("sim_empty", 1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    chk("sim_empty.rdata_const", 32'(r_data), 32'h55);
    chk("sim_empty.udf_const", 32'(underflow), 32'd0);
    for (int i = 0; i < 15; i++) cyc("sim_fill", 1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b1);
    cyc("sim_full", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1);
    chk("sim_full.head_const", 32'(r_data), 32'h60);
    for (int i = 0; i < 16; i++) cyc("sim_drain", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // underflow and clear priority
    cyc("udf_set", 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("udf.set_const", 32'(underflow), 32'd1);
    cyc("udf_clr", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf.clr_const", 32'(underflow), 32'd0);
    cyc("udf_clr_rd", 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("udf.win_const", 32'(underflow), 32'd1);

    // reset mid-stream
    for (int i = 0; i < 5; i++) cyc("mid_push", 1'b1, 1'b0, 8'(8'h30 + i), 1'b0, 1'b1);
    cyc("mid_reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc("mid_push", 1'b1, 1'b0, 8'h7E, 1'b0, 1'b1);
    chk("mid.rdata_const", 32'(r_data), 32'h7E);

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int n = 0; n < 3000; n++) begin
      phase_bias = ((n / 150) % 2 == 0) ? 70 : 30;
      cyc("rand",
          ($urandom_range(0, 99) < phase_bias),
          ($urandom_range(0, 99) < (100 - phase_bias)),
          8'($urandom),
          ($urandom_range(0, 99) < 5),
          !($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
